// File: rtl/plasticity_scheduler.sv
// Round-robin scheduler that serves one weight-multiply/learn transaction at a time.
// Define PLASTIC_WEIGHT_SAT_EN to saturate weight updates; otherwise they wrap modulo 2^16.
module plasticity_scheduler #(
    parameter int                 NUM_REQ       = 4,
    parameter int                 NUM_NEURONS   = 8,
    parameter logic signed [15:0] LEARNING_RATE = 16'sd10,
    parameter logic signed [15:0] INIT_WEIGHT   = 16'sd999,
    localparam int                NIDX          = $clog2(NUM_NEURONS),
    localparam int                IDW           = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*NIDX-1:0]   req_neuron,
    input  logic [NUM_REQ*16-1:0]     req_input,
    input  logic [NUM_REQ*16-1:0]     req_error,
    input  logic [NUM_REQ-1:0]        req_learn,
    input  logic                      learn_enable,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic signed [31:0]        rsp_data,
    output logic                      busy
);

`ifdef PLASTIC_WEIGHT_SAT_EN
    localparam int SW = 17;
`else
    localparam int SW = 16;
`endif

    typedef enum logic [1:0] {IDLE, COMPUTE, UPDATE, RESPOND} state_t;

    state_t                   state, state_next;
    logic [IDW-1:0]           rr_ptr, grant_id, cap_id;
    logic                     grant_any, accept;
    logic [NIDX-1:0]          cap_neuron;
    logic signed [15:0]       cap_input, cap_error;
    logic                     cap_learn;
    logic signed [31:0]       product, mult;
    logic signed [15:0]       weight [NUM_NEURONS];
    logic signed [15:0]       cur_w, upd_w;
    logic signed [SW-1:0]     sum_w;
    int                       idx;

    // Search upward from the pointer with wrap-around for the first valid requester.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    assign accept    = (state == IDLE) && grant_any && rst_n;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = COMPUTE;
            COMPUTE: state_next = UPDATE;
            UPDATE:  state_next = RESPOND;
            RESPOND: if (rsp_valid && rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Learning rule: only a positive input moves the weight, in the direction of the error sign.
    always_comb begin
        cur_w = weight[cap_neuron];
        mult  = 32'(cap_input) * 32'(cur_w);
        if (cap_learn && cap_input > 16'sd0 && cap_error > 16'sd0)
            sum_w = SW'(cur_w) + SW'(LEARNING_RATE);
        else if (cap_learn && cap_input > 16'sd0 && cap_error < 16'sd0)
            sum_w = SW'(cur_w) - SW'(LEARNING_RATE);
        else
            sum_w = SW'(cur_w);
`ifdef PLASTIC_WEIGHT_SAT_EN
        if (sum_w[16] != sum_w[15]) upd_w = sum_w[16] ? 16'sh8000 : 16'sh7fff;
        else                        upd_w = sum_w[15:0];
`else
        upd_w = sum_w;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            cap_id     <= '0;
            cap_neuron <= '0;
            cap_input  <= '0;
            cap_error  <= '0;
            cap_learn  <= 1'b0;
            product    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) weight[i] <= INIT_WEIGHT;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cap_id     <= grant_id;
                    cap_neuron <= req_neuron[int'(grant_id)*NIDX +: NIDX];
                    cap_input  <= req_input[int'(grant_id)*16 +: 16];
                    cap_error  <= req_error[int'(grant_id)*16 +: 16];
                    cap_learn  <= req_learn[grant_id] && learn_enable;
                    rr_ptr     <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                end
                COMPUTE: product <= mult;
                UPDATE: begin
                    weight[cap_neuron] <= upd_w;
                    rsp_valid          <= 1'b1;
                    rsp_id             <= cap_id;
                    rsp_data           <= product;
                end
                RESPOND: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_plasticity_scheduler.sv
// Directed scoreboard bench for plasticity_scheduler; a second instance starts near the weight limit.
module tb_plasticity_scheduler;
    localparam int NR   = 4;
    localparam int NN   = 8;
    localparam int NIDX = 3;
`ifdef PLASTIC_WEIGHT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct { int id; int data; int sdata; } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NR-1:0]         req_valid, req_learn, req_ready, s_req_ready;
    logic [NR*NIDX-1:0]    req_neuron;
    logic [NR*16-1:0]      req_input, req_error;
    logic                  learn_enable, rsp_ready;
    logic                  rsp_valid, s_rsp_valid, busy, s_busy;
    logic [1:0]            rsp_id, s_rsp_id;
    logic signed [31:0]    rsp_data, s_rsp_data;

    exp_t sb[$];
    int   mw[NN];
    int   sw[NN];
    int   mptr;
    int   total = 0;
    int   bad = 0;
    int   last_sdata;

    always #5 clk = ~clk;

    plasticity_scheduler #(.NUM_REQ(NR), .NUM_NEURONS(NN)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_neuron(req_neuron), .req_input(req_input), .req_error(req_error),
        .req_learn(req_learn), .learn_enable(learn_enable), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    plasticity_scheduler #(.NUM_REQ(NR), .NUM_NEURONS(NN), .INIT_WEIGHT(16'sd32760)) u_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_neuron(req_neuron), .req_input(req_input), .req_error(req_error),
        .req_learn(req_learn), .learn_enable(learn_enable), .rsp_valid(s_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data), .busy(s_busy)
    );

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic signed [63:0] obs,
                                input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int next_w(int w, int din, int derr, bit lf);
        int s;
        s = w;
        if (lf && din > 0 && derr > 0)      s = w + 10;
        else if (lf && din > 0 && derr < 0) s = w - 10;
        if (s > 32767)  s = SAT ? 32767 : s - 65536;
        if (s < -32768) s = SAT ? -32768 : s + 65536;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NN; i++) begin
            mw[i] = 999;
            sw[i] = 32760;
        end
        mptr = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check_output("rst_valid", rsp_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_id", rsp_id, 0);
        check_output("rst_data", rsp_data, 0);
        check_output("rst_sdata", s_rsp_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_req(input int r, input int n, input int din, input int derr, input bit lf);
        req_neuron[r*NIDX +: NIDX] = n[NIDX-1:0];
        req_input[r*16 +: 16]      = din[15:0];
        req_error[r*16 +: 16]      = derr[15:0];
        req_learn[r]               = lf;
        req_valid[r]               = 1'b1;
    endtask

    // Push the expected response for requester r and advance the weight model.
    task automatic push_expected(input int r);
        exp_t e;
        int   n, din, derr;
        bit   lf;
        n    = int'(req_neuron[r*NIDX +: NIDX]);
        din  = int'($signed(req_input[r*16 +: 16]));
        derr = int'($signed(req_error[r*16 +: 16]));
        lf   = req_learn[r] && learn_enable;
        e.id    = r;
        e.data  = din * mw[n];
        e.sdata = din * sw[n];
        sb.push_back(e);
        mw[n] = next_w(mw[n], din, derr, lf);
        sw[n] = next_w(sw[n], din, derr, lf);
        mptr  = (r + 1) % NR;
    endtask

    task automatic apply_request(input int r);
        #1;
        check_output("grant", req_ready, 1 << r);
        check_output("busy_idle", busy, 0);
        push_expected(r);
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
    endtask

    task automatic check_response(input int stall);
        exp_t e;
        check_output("lat_e1", rsp_valid, 0);
        check_output("busy_run", busy, 1);
        @(negedge clk);
        check_output("lat_e2", rsp_valid, 0);
        @(negedge clk);
        check_output("lat_e3", rsp_valid, 1);
        check_output("sb_depth", sb.size(), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (stall > 0) rsp_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            check_output("stall_valid", rsp_valid, 1);
            check_output("stall_id", rsp_id, e.id);
            check_output("stall_data", rsp_data, e.data);
            check_output("stall_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check_output("rsp_id", rsp_id, e.id);
        check_output("rsp_data", rsp_data, e.data);
        check_output("rsp_sdata", s_rsp_data, e.sdata);
        last_sdata = int'(s_rsp_data);
        @(negedge clk);
        check_output("rsp_done", rsp_valid, 0);
        check_output("idle_busy", busy, 0);
    endtask

    initial begin
        int grants;
        req_valid    = '0;
        req_learn    = '0;
        req_neuron   = '0;
        req_input    = '0;
        req_error    = '0;
        learn_enable = 1'b0;
        rsp_ready    = 1'b1;
        last_sdata   = 0;
        do_reset();

        set_req(1, 2, 3, 0, 0); apply_request(1); check_response(0);
        set_req(0, 2, 1, 0, 0); apply_request(0); check_response(0);

        learn_enable = 1'b1;
        set_req(2, 0, 5, 7, 1); apply_request(2); check_response(0);
        set_req(3, 0, 1, 0, 0); apply_request(3); check_response(0);

        learn_enable = 1'b0;
        set_req(0, 4, 5, -1, 1); apply_request(0); check_response(0);
        set_req(0, 4, 1, 0, 0);  apply_request(0); check_response(0);
        learn_enable = 1'b1;
        set_req(0, 4, 5, -1, 1); apply_request(0); check_response(0);
        set_req(1, 4, 1, 0, 0);  apply_request(1); check_response(0);

        set_req(2, 6, 3, 4, 1); apply_request(2); check_response(0);
        set_req(2, 6, 1, 0, 0); apply_request(2); check_response(0);
        check_output("sat_edge", last_sdata, SAT ? 32767 : -32766);

        // Stalled response with a competing request waiting behind it.
        set_req(0, 1, 2, 0, 0); apply_request(0);
        set_req(3, 5, 4, 0, 0);
        check_response(5);
        apply_request(3); check_response(0);

        // Reset in UPDATE discards the transaction and its weight change.
        set_req(1, 7, 6, 2, 1); apply_request(1);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(2, 7, 1, 0, 0);
        #1;
        check_output("mid_rst_valid", rsp_valid, 0);
        check_output("mid_rst_busy", busy, 0);
        check_output("mid_rst_ready", req_ready, 0);
        check_output("mid_rst_data", rsp_data, 0);
        check_output("mid_rst_id", rsp_id, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply_request(2); check_response(0);

        // All requesters contending: grants rotate 0,1,2,3,0.
        do_reset();
        for (int r = 0; r < NR; r++) set_req(r, r, r + 1, 0, 0);
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_valid) begin
                check_output("rr_sb_depth", sb.size(), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("rr_id", rsp_id, e.id);
                    check_output("rr_data", rsp_data, e.data);
                    check_output("rr_sdata", s_rsp_data, e.sdata);
                end
            end
            if (req_ready != '0) begin
                check_output("rr_grant", req_ready, 1 << mptr);
                push_expected(mptr);
                grants++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        check_output("rr_grants", grants, 5);
        check_output("rr_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
